// File: rtl/mmio_perf_counters.sv
// mmio_perf_counters: bank of NUM_CNT memory-mapped event counters with a
// shared control/status register (CLEAR, FREEZE, sticky per-counter OVF).
// Counter i lives at BASE_ADDR + 4*i. The control register lives at CTRL_ADDR.
// Read data is registered and returns one cycle after an accepted read.
// Build option MMIO_PERF_COUNTERS_SATURATE_EN: when defined, an increment at
// all-ones holds the counter at all-ones instead of wrapping to 0. OVF is set
// in both builds.
module mmio_perf_counters #(
  parameter int                 W_SIZE    = 32,
  parameter int                 NUM_CNT   = 4,
  parameter int                 CNT_W     = 32,
  parameter logic [W_SIZE-1:0]  BASE_ADDR = 32'h80000010,
  parameter logic [W_SIZE-1:0]  CTRL_ADDR = 32'h80000040
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CNT-1:0]  inc,
  input  logic [W_SIZE-1:0]   addr,
  input  logic                re,
  input  logic                we,
  input  logic [W_SIZE-1:0]   wdata,
  output logic                hit,
  output logic [W_SIZE-1:0]   rdata,
  output logic                rvalid,
  output logic [NUM_CNT-1:0]  ovf
);

  localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  // Address decode signals.
  logic [W_SIZE-3:0]  word_off;
  logic               cnt_sel;
  logic               ctrl_sel;
  logic [IDX_W-1:0]   cnt_idx;
  logic               ctrl_wr;
  logic               clear;

  // Architectural state.
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic               freeze_q, freeze_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [NUM_CNT-1:0] ovf_set;
  logic [W_SIZE-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic [W_SIZE-1:0]  rd_val;
  logic               unused_bits;

  // The low address bits and the unmapped write-data bits carry no meaning here.
  assign unused_bits = ^{addr[1:0], wdata};

  // Word offset from counter 0. An address below the base wraps to a large
  // offset, so a single unsigned compare covers both range ends.
  assign word_off = addr[W_SIZE-1:2] - BASE_ADDR[W_SIZE-1:2];
  assign cnt_sel  = (word_off < (W_SIZE-2)'(NUM_CNT));
  assign cnt_idx  = word_off[IDX_W-1:0];
  assign ctrl_sel = (addr[W_SIZE-1:2] == CTRL_ADDR[W_SIZE-1:2]);
  assign hit      = cnt_sel | ctrl_sel;

  assign ctrl_wr  = we & ctrl_sel;
  assign clear    = ctrl_wr & wdata[0];

  // Per-counter next value: clear, then MMIO load, then gated increment.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (we && cnt_sel && (cnt_idx == IDX_W'(i))) begin
        cnt_d[i] = wdata[CNT_W-1:0];
      end else if (inc[i] && !freeze_q) begin
        if (&cnt_q[i]) begin
          ovf_set[i] = 1'b1;
`ifdef MMIO_PERF_COUNTERS_SATURATE_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Control register next state; a new overflow wins over a same-cycle W1C.
  always_comb begin
    freeze_d = freeze_q;
    ovf_d    = ovf_q;
    if (ctrl_wr) begin
      freeze_d = wdata[1];
      ovf_d    = ovf_q & ~wdata[8 +: NUM_CNT];
    end
    ovf_d = ovf_d | ovf_set;
  end

  // Read mux over pre-edge state, captured only for accepted reads.
  always_comb begin
    rd_val = '0;
    if (ctrl_sel) begin
      rd_val[1]            = freeze_q;
      rd_val[8 +: NUM_CNT] = ovf_q;
    end else if (cnt_sel) begin
      rd_val[CNT_W-1:0] = cnt_q[cnt_idx];
    end
    rvalid_d = re & hit;
    rdata_d  = (re && hit) ? rd_val : rdata_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
      freeze_q <= 1'b0;
      ovf_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      freeze_q <= freeze_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mmio_perf_counters.sv
// Testbench for mmio_perf_counters: directed walk through counting, load
// collisions, overflow, freeze/clear, decode misses and async reset, followed
// by a randomized phase. A behavioural model of the register map is checked
// against the DUT at every falling clock edge.
module tb_mmio_perf_counters;

  localparam int          NUM_CNT = 4;
  localparam logic [31:0] BASE    = 32'h80000010;
  localparam logic [31:0] CTRL    = 32'h80000040;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_CNT-1:0] inc;
  logic [31:0]        addr;
  logic               re, we;
  logic [31:0]        wdata;
  logic               hit;
  logic [31:0]        rdata;
  logic               rvalid;
  logic [NUM_CNT-1:0] ovf;

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_en = 1'b0;

  mmio_perf_counters dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc),
    .addr   (addr),
    .re     (re),
    .we     (we),
    .wdata  (wdata),
    .hit    (hit),
    .rdata  (rdata),
    .rvalid (rvalid),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0]        m_cnt [NUM_CNT];
  logic               m_frz    = 1'b0;
  logic [NUM_CNT-1:0] m_ovf    = '0;
  logic [31:0]        m_rdata  = '0;
  logic               m_rvalid = 1'b0;

  logic [31:0]        o_cnt [NUM_CNT];
  logic               o_frz;
  logic [NUM_CNT-1:0] o_ovf;
  logic [NUM_CNT-1:0] n_set;
  logic [31:0]        w_adr;
  bit                 is_ctl, is_cnt;
  int                 k;
  longint unsigned    sum;

  function automatic bit m_hit(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    return (w == CTRL) || (w >= BASE && w < BASE + 32'(4 * NUM_CNT));
  endfunction

  initial for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = '0;
      m_frz = 1'b0; m_ovf = '0; m_rdata = '0; m_rvalid = 1'b0;
    end else begin
      w_adr  = addr & ~32'h3;
      is_ctl = (w_adr == CTRL);
      is_cnt = (w_adr >= BASE) && (w_adr < BASE + 32'(4 * NUM_CNT));
      k      = int'((w_adr - BASE) / 4);
      o_cnt  = m_cnt;
      o_frz  = m_frz;
      o_ovf  = m_ovf;
      n_set  = '0;
      if (re && (is_ctl || is_cnt)) begin
        m_rvalid = 1'b1;
        m_rdata  = is_ctl ? {20'b0, o_ovf, 6'b0, o_frz, 1'b0} : o_cnt[k];
      end else begin
        m_rvalid = 1'b0;
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        if (we && is_ctl && wdata[0]) m_cnt[i] = '0;
        else if (we && is_cnt && k == i) m_cnt[i] = wdata;
        else if (inc[i] && !o_frz) begin
          sum = longint'(o_cnt[i]) + 1;
          if (sum > 64'hFFFF_FFFF) begin
            n_set[i] = 1'b1;
`ifdef MMIO_PERF_COUNTERS_SATURATE_EN
            m_cnt[i] = 32'hFFFF_FFFF;
`else
            m_cnt[i] = 32'h0;
`endif
          end else begin
            m_cnt[i] = sum[31:0];
          end
        end
      end
      if (we && is_ctl) begin
        m_frz = wdata[1];
        m_ovf = m_ovf & ~wdata[8 +: NUM_CNT];
      end
      m_ovf = m_ovf | n_set;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_hit",    32'(hit),    32'(m_hit(addr)));
      chk("model_rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("model_rdata",  rdata,       m_rdata);
      chk("model_ovf",    32'(ovf),    32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr = a; re = 1'b1;
    cyc();
    re = 1'b0;
    chk({nm, "_rvalid"}, 32'(rvalid), 32'h1);
    chk(nm, rdata, exp);
  endtask

  logic [31:0] c2_exp;
  logic [31:0] rnd;

  initial begin
`ifdef MMIO_PERF_COUNTERS_SATURATE_EN
    c2_exp = 32'hFFFF_FFFF;
`else
    c2_exp = 32'h0;
`endif
    rst_n = 1'b1; inc = '0; addr = '0; re = 1'b0; we = 1'b0; wdata = '0;
    #2 rst_n = 1'b0;
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("reset_rdata",  rdata,        32'h0);
    chk("reset_rvalid", 32'(rvalid),  32'h0);
    chk("reset_ovf",    32'(ovf),     32'h0);
    rst_n = 1'b1;
    cyc();

    // count ten events on counter 0
    inc = 4'b0001;
    repeat (10) cyc();
    inc = '0;
    rd_check("cnt0_after_10", BASE, 32'd10);
    for (int i = 1; i < NUM_CNT; i++) rd_check("cnt_idle_zero", BASE + 32'(4 * i), 32'h0);

    // load, then load colliding with an increment
    wr(BASE + 4, 32'hFFFF_FFFE);
    inc = 4'b0010;
    wr(BASE + 4, 32'h5);
    inc = '0;
    rd_check("cnt1_load_collision", BASE + 4, 32'h5);

    // overflow on counter 2, then W1C
    wr(BASE + 8, 32'hFFFF_FFFF);
    inc = 4'b0100; cyc(); inc = '0;
    rd_check("cnt2_overflow", BASE + 8, c2_exp);
    chk("ovf2_set", 32'(ovf), 32'h4);
    rd_check("ctrl_ovf_bit10", CTRL, 32'h400);
    wr(CTRL, 32'h400);
    chk("ovf2_w1c", 32'(ovf), 32'h0);

    // set overflow again so the clear can show it is preserved
    wr(BASE + 8, 32'hFFFF_FFFF);
    inc = 4'b0100; cyc(); inc = '0;

    // freeze, then clear
    wr(CTRL, 32'h2);
    rd_check("ctrl_freeze", CTRL, 32'h402);
    inc = 4'hF;
    repeat (5) cyc();
    inc = '0;
    rd_check("frz_cnt0", BASE,      32'd10);
    rd_check("frz_cnt1", BASE + 4,  32'd5);
    rd_check("frz_cnt2", BASE + 8,  c2_exp);
    rd_check("frz_cnt3", BASE + 12, 32'd0);
    wr(CTRL, 32'h1);
    for (int i = 0; i < NUM_CNT; i++) rd_check("clear_cnt", BASE + 32'(4 * i), 32'h0);
    rd_check("ctrl_after_clear", CTRL, 32'h400);
    chk("ovf_kept_by_clear", 32'(ovf), 32'h4);

    // decode miss
    addr = 32'h8000_0030; re = 1'b1;
    #1 chk("miss_hit", 32'(hit), 32'h0);
    cyc();
    re = 1'b0;
    chk("miss_rvalid", 32'(rvalid), 32'h0);

    // async reset with a read in flight
    inc = 4'hF; repeat (3) cyc(); inc = '0;
    addr = BASE; re = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvalid), 32'h0);
    chk("arst_ovf",    32'(ovf),    32'h0);
    chk("arst_rdata",  rdata,       32'h0);
    re = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < NUM_CNT; i++) rd_check("arst_cnt", BASE + 32'(4 * i), 32'h0);
    rd_check("arst_ctrl", CTRL, 32'h0);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      inc = 4'($urandom);
      re  = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: addr = BASE + 32'(4 * $urandom_range(0, NUM_CNT - 1));
        4:          addr = CTRL;
        5:          addr = 32'h8000_0030;
        6:          addr = BASE - 32'h4;
        default:    addr = BASE + 32'(4 * $urandom_range(0, NUM_CNT - 1)) + 32'($urandom_range(1, 3));
      endcase
      if ((addr & ~32'h3) == CTRL) begin
        rnd   = $urandom;
        wdata = rnd & 32'hFFFF_FFFE;
        if ($urandom_range(0, 15) == 0) wdata[0] = 1'b1;
        if ($urandom_range(0, 2) != 0)  wdata[1] = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      end else begin
        wdata = $urandom;
      end
      cyc();
    end
    inc = '0; re = 1'b0; we = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
